// File: rtl/stream_mux.sv
// Registered N-channel stream multiplexer with valid/ready handshakes.
// Round-robin (MODE 0) or fixed lowest-index priority (MODE 1) arbitration in one register stage.
module stream_mux #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MODE     = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [CHANNELS*WIDTH-1:0] i_in_data,
    input  logic [CHANNELS-1:0]       i_in_valid,
    output logic [CHANNELS-1:0]       o_in_ready,
    output logic [WIDTH-1:0]          o_out,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [3:0]                o_out_sel
);

    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_out_sel;
    logic             r_out_valid;
    logic [3:0]       r_ptr;

    logic             w_load;
    logic             w_found;
    logic             w_grant;
    logic [3:0]       w_win;
    logic [15:0]      w_valid_ext;
    logic [WIDTH-1:0] w_data;

    assign w_load      = !r_out_valid || i_out_ready;
    assign w_grant     = w_load && w_found && !i_reset;
    assign w_valid_ext = 16'(i_in_valid);

    // Scan channels starting at the pointer (MODE 0) or at channel 0 (MODE 1).
    always_comb begin
        logic [4:0] v_idx;
        w_found = 1'b0;
        w_win   = 4'd0;
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (MODE == 0) begin
                v_idx = 5'(r_ptr) + 5'(j);
                if (v_idx >= 5'(CHANNELS)) begin
                    v_idx = v_idx - 5'(CHANNELS);
                end
            end else begin
                v_idx = 5'(j);
            end
            if (!w_found && w_valid_ext[v_idx[3:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[3:0];
            end
        end
    end

    always_comb begin
        w_data     = '0;
        o_in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_win == 4'(i)) begin
                w_data = i_in_data[i*WIDTH +: WIDTH];
            end
            o_in_ready[i] = w_grant && (w_win == 4'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out       <= '0;
            r_out_sel   <= 4'd0;
            r_out_valid <= 1'b0;
            r_ptr       <= 4'd0;
        end else if (w_load) begin
            if (w_found) begin
                r_out       <= w_data;
                r_out_sel   <= w_win;
                r_out_valid <= 1'b1;
                if (MODE == 0) begin
                    r_ptr <= (w_win == 4'(CHANNELS - 1)) ? 4'd0 : w_win + 4'd1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out       = r_out;
    assign o_out_sel   = r_out_sel;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: a round-robin and a fixed-priority instance share stimulus and are
// checked against a behavioural model, plus directed checks for the key scenarios.
module tb_stream_mux;
    localparam int W = 16;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   in_valid;
    logic           out_ready;

    logic [C-1:0] rdy_rr, rdy_fp;
    logic [W-1:0] out_rr, out_fp;
    logic         ov_rr, ov_fp;
    logic [3:0]   sel_rr, sel_fp;

    int n_pass  = 0;
    int n_total = 0;

    // Model state, index 0 = round-robin, 1 = fixed priority
    logic [W-1:0] m_out[2];
    logic [3:0]   m_sel[2];
    logic         m_valid[2];
    int           m_ptr[2];

    always #5 clk = ~clk;

    stream_mux #(.WIDTH(W), .CHANNELS(C), .MODE(0)) dut_rr (
        .i_clk(clk), .i_reset(reset), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(rdy_rr), .o_out(out_rr), .o_out_valid(ov_rr),
        .i_out_ready(out_ready), .o_out_sel(sel_rr)
    );

    stream_mux #(.WIDTH(W), .CHANNELS(C), .MODE(1)) dut_fp (
        .i_clk(clk), .i_reset(reset), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(rdy_fp), .o_out(out_fp), .o_out_valid(ov_fp),
        .i_out_ready(out_ready), .o_out_sel(sel_fp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Channel chosen by the arbitration rule, or -1 when nothing is valid.
    function automatic int winner(input int m, input int ptr, input logic [C-1:0] v);
        for (int k = 0; k < C; k++) begin
            int ch;
            ch = (m == 0) ? (ptr + k) % C : k;
            if (v[ch]) return ch;
        end
        return -1;
    endfunction

    function automatic logic [C-1:0] exp_ready(input int m);
        int k;
        logic [C-1:0] r;
        r = '0;
        k = winner(m, m_ptr[m], in_valid);
        if (!reset && (!m_valid[m] || out_ready) && k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_edge(input int m);
        int k;
        if (reset) begin
            m_out[m] = '0; m_sel[m] = 4'd0; m_valid[m] = 1'b0; m_ptr[m] = 0;
        end else if (!m_valid[m] || out_ready) begin
            k = winner(m, m_ptr[m], in_valid);
            if (k >= 0) begin
                m_out[m]   = in_data[k*W +: W];
                m_sel[m]   = 4'(k);
                m_valid[m] = 1'b1;
                if (m == 0) m_ptr[m] = (k + 1) % C;
            end else begin
                m_valid[m] = 1'b0;
            end
        end
    endtask

    // One clock: check handshake before the edge, advance model, check outputs after it.
    task automatic tick();
        #1;
        chk("rr_in_ready", 32'(rdy_rr), 32'(exp_ready(0)));
        chk("fp_in_ready", 32'(rdy_fp), 32'(exp_ready(1)));
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("rr_out_valid", 32'(ov_rr), 32'(m_valid[0]));
        chk("fp_out_valid", 32'(ov_fp), 32'(m_valid[1]));
        chk("rr_out", 32'(out_rr), 32'(m_out[0]));
        chk("fp_out", 32'(out_fp), 32'(m_out[1]));
        chk("rr_sel", 32'(sel_rr), 32'(m_sel[0]));
        chk("fp_sel", 32'(sel_fp), 32'(m_sel[1]));
        chk("rr_ptr", 32'(dut_rr.r_ptr), 32'(m_ptr[0]));
        chk("fp_ptr", 32'(dut_fp.r_ptr), 32'd0);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_out[m] = '0; m_sel[m] = 4'd0; m_valid[m] = 1'b0; m_ptr[m] = 0;
        end
        in_data   = '0;
        out_ready = 1'b0;

        // Reset with all inputs valid
        reset    = 1'b1;
        in_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("reset_in_ready", 32'({rdy_rr, rdy_fp}), 32'd0);
            tick();
        end
        chk("reset_out", 32'(out_rr), 32'd0);
        chk("reset_sel", 32'(sel_rr), 32'd0);
        chk("reset_valid", 32'(ov_rr), 32'd0);

        // Round-robin fairness
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < C; i++) in_data[i*W +: W] = 16'hA000 + 16'(i);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rr_fair_out", 32'(out_rr), 32'(16'hA000 + 16'(c % 4)));
            chk("rr_fair_sel", 32'(sel_rr), 32'(c % 4));
            chk("rr_fair_valid", 32'(ov_rr), 32'd1);
        end

        // Fixed priority
        in_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("fp_ready3_low", 32'(rdy_fp[3]), 32'd0);
            tick();
            chk("fp_sel_1", 32'(sel_fp), 32'd1);
        end
        in_valid = 4'b1000;
        tick();
        chk("fp_sel_3", 32'(sel_fp), 32'd3);

        // Back-pressure
        in_valid = 4'b0000;
        tick();
        in_data[0*W +: W] = 16'h1234;
        in_valid = 4'b0001;
        tick();
        chk("bp_loaded", 32'(out_rr), 32'h1234);
        in_data[2*W +: W] = 16'h5678;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_no_ready", 32'(rdy_rr), 32'd0);
            tick();
            chk("bp_hold_out", 32'(out_rr), 32'h1234);
            chk("bp_hold_valid", 32'(ov_rr), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_out", 32'(out_rr), 32'h5678);
        chk("bp_next_sel", 32'(sel_rr), 32'd2);
        chk("bp_next_valid", 32'(ov_rr), 32'd1);

        // Sparse input and pointer wrap, from a fresh pointer
        in_valid = 4'b0000;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 4'b1000;
        tick();
        chk("wrap_sel", 32'(sel_rr), 32'd3);
        chk("wrap_ptr", 32'(dut_rr.r_ptr), 32'd0);
        in_valid = 4'b0001;
        tick();
        chk("sparse_sel", 32'(sel_rr), 32'd0);
        chk("sparse_ptr", 32'(dut_rr.r_ptr), 32'd1);
        in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(ov_rr), 32'd0);

        // Reset mid-transfer discards the held word
        in_valid = 4'b0010;
        tick();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        tick();
        chk("mid_held", 32'(ov_rr), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(ov_rr), 32'd0);
        chk("mid_rst_ptr", 32'(dut_rr.r_ptr), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_not_delivered", 32'(ov_rr), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < C; i++) in_data[i*W +: W] = 16'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
